tic_tac_toe_turn_arbiter: RTL and testbench

//  Sequences one tic-tac-toe game by sharing the single board datapath (tic_tac_toe_game) between X and O.

---
 rtl/tic_tac_toe_turn_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_tic_tac_toe_turn_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tic_tac_toe_turn_arbiter.sv
// Turn arbiter for one tic-tac-toe game: serialises X/O move requests onto the shared
// board datapath, rejects illegal or occupied squares, and declares win, draw or game over.
// Ports: clk_i/reset_i (sync, active-low); start_i; x_/o_ req_i, pos_i, ack_o; reject_o;
//   game_clear_o, move_valid_o, move_player_o, move_pos_o to the datapath; game_winner_i from it;
//   turn_o, move_count_o, game_over_o, result_o status. All outputs are registered.
// Optional: define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYCLES idle cycles.
module tic_tac_toe_turn_arbiter #(
  parameter bit          FIRST_PLAYER   = 1'b0,
  parameter int unsigned RESULT_LAT     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       x_req_i,
  input  logic [3:0] x_pos_i,
  output logic       x_ack_o,
  input  logic       o_req_i,
  input  logic [3:0] o_pos_i,
  output logic       o_ack_o,
  output logic       reject_o,
  output logic       game_clear_o,
  output logic       move_valid_o,
  output logic       move_player_o,
  output logic [3:0] move_pos_o,
  input  logic [1:0] game_winner_i,
  output logic       turn_o,
  output logic [3:0] move_count_o,
  output logic       game_over_o,
  output logic [1:0] result_o
);

  if (RESULT_LAT < 1 || RESULT_LAT > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("tic_tac_toe_turn_arbiter: RESULT_LAT must be 1..7 and TIMEOUT_CYCLES 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_X_TURN, S_O_TURN, S_WAIT, S_DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(RESULT_LAT);

  state_t     state_q;
  logic [8:0] occ_q;          // bit k-1 set when square k is taken
  logic [2:0] lat_q;
  logic       x_ack_q, o_ack_q, reject_q, game_clear_q, move_valid_q, move_player_q;
  logic [3:0] move_pos_q, move_count_q;
  logic       turn_q, game_over_q;
  logic [1:0] result_q;

  // Current mover's request, as seen from the active turn state.
  logic       cur_player;
  logic       cur_req;
  logic [3:0] cur_pos;
  logic       cur_ack;
  logic       req_seen;
  logic       legal;

  assign cur_player = (state_q == S_O_TURN);
  assign cur_req    = cur_player ? o_req_i : x_req_i;
  assign cur_pos    = cur_player ? o_pos_i : x_pos_i;
  assign cur_ack    = cur_player ? o_ack_q : x_ack_q;
  // A request still high on its own ack cycle belongs to the move just consumed.
  assign req_seen   = ((state_q == S_X_TURN) || (state_q == S_O_TURN)) && cur_req && !cur_ack;
  // Range test first so the occupancy index is only meaningful for squares 1..9.
  assign legal      = (cur_pos >= 4'd1) && (cur_pos <= 4'd9) && !occ_q[cur_pos - 4'd1];

`ifdef TURN_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      occ_q         <= '0;
      lat_q         <= '0;
      x_ack_q       <= 1'b0;
      o_ack_q       <= 1'b0;
      reject_q      <= 1'b0;
      game_clear_q  <= 1'b0;
      move_valid_q  <= 1'b0;
      move_player_q <= 1'b0;
      move_pos_q    <= '0;
      turn_q        <= 1'b0;
      move_count_q  <= '0;
      game_over_q   <= 1'b0;
      result_q      <= '0;
`ifdef TURN_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      x_ack_q      <= 1'b0;
      o_ack_q      <= 1'b0;
      reject_q     <= 1'b0;
      game_clear_q <= 1'b0;
      move_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_CLEAR;
            game_clear_q <= 1'b1;
            occ_q        <= '0;
            move_count_q <= '0;
            result_q     <= '0;
            game_over_q  <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_q <= FIRST_PLAYER ? S_O_TURN : S_X_TURN;
          turn_q  <= FIRST_PLAYER;
`ifdef TURN_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        S_X_TURN, S_O_TURN: begin
          if (req_seen) begin
            if (cur_player) o_ack_q <= 1'b1;
            else            x_ack_q <= 1'b1;
            if (legal) begin
              move_valid_q           <= 1'b1;
              move_player_q          <= cur_player;
              move_pos_q             <= cur_pos;
              occ_q[cur_pos - 4'd1]  <= 1'b1;
              if (move_count_q < 4'd9) move_count_q <= move_count_q + 4'd1;
              lat_q                  <= '0;
              turn_q                 <= 1'b0;
              state_q                <= S_WAIT;
            end else begin
              reject_q <= 1'b1;
            end
          end
`ifdef TURN_TIMEOUT_EN
          // Idle cycles only; a request on the expiry cycle is served above instead.
          else if (!cur_req) begin
            if (to_cnt_q == TO_LAST) begin
              state_q  <= cur_player ? S_X_TURN : S_O_TURN;
              turn_q   <= !cur_player;
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + 8'd1;
            end
          end
`endif
        end
        S_WAIT: begin
          if (lat_q == LAT) begin
            // 2'b11 is undefined from the datapath and falls through as "no winner".
            if (game_winner_i == 2'b01 || game_winner_i == 2'b10) begin
              result_q    <= game_winner_i;
              game_over_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (move_count_q == 4'd9) begin
              result_q    <= 2'b11;
              game_over_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= move_player_q ? S_X_TURN : S_O_TURN;
              turn_q  <= !move_player_q;
`ifdef TURN_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_ack_o       = x_ack_q;
  assign o_ack_o       = o_ack_q;
  assign reject_o      = reject_q;
  assign game_clear_o  = game_clear_q;
  assign move_valid_o  = move_valid_q;
  assign move_player_o = move_player_q;
  assign move_pos_o    = move_pos_q;
  assign turn_o        = turn_q;
  assign move_count_o  = move_count_q;
  assign game_over_o   = game_over_q;
  assign result_o      = result_q;

endmodule

// File: tb/tb_tic_tac_toe_turn_arbiter.sv
// Bench for tic_tac_toe_turn_arbiter: drives scripted games through the req/ack ports,
// models the board/winner datapath with one cycle of result latency, and scoreboards
// every issued move against the queue of moves expected to be accepted.
module tb_tic_tac_toe_turn_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       x_req, o_req;
  logic [3:0] x_pos, o_pos;
  logic       x_ack, o_ack, reject, game_clear, move_valid, move_player;
  logic [3:0] move_pos, move_count;
  logic [1:0] game_winner, result;
  logic       turn, game_over;

  always #5 clk = ~clk;

  tic_tac_toe_turn_arbiter #(
    .FIRST_PLAYER  (1'b0),
    .RESULT_LAT    (1),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .x_req_i      (x_req),
    .x_pos_i      (x_pos),
    .x_ack_o      (x_ack),
    .o_req_i      (o_req),
    .o_pos_i      (o_pos),
    .o_ack_o      (o_ack),
    .reject_o     (reject),
    .game_clear_o (game_clear),
    .move_valid_o (move_valid),
    .move_player_o(move_player),
    .move_pos_o   (move_pos),
    .game_winner_i(game_winner),
    .turn_o       (turn),
    .move_count_o (move_count),
    .game_over_o  (game_over),
    .result_o     (result)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

`ifdef TURN_TIMEOUT_EN
  localparam int OUT_OF_TURN_HOLD = 3;
  localparam bit TURN_AFTER_IDLE  = 1'b1;
`else
  localparam int OUT_OF_TURN_HOLD = 20;
  localparam bit TURN_AFTER_IDLE  = 1'b0;
`endif

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Datapath model: board masks, square k at bit k-1.
  logic [8:0] xb, ob;

  function automatic bit has_line(input logic [8:0] b);
    return ((b & 9'b000000111) == 9'b000000111) || ((b & 9'b000111000) == 9'b000111000) ||
           ((b & 9'b111000000) == 9'b111000000) || ((b & 9'b001001001) == 9'b001001001) ||
           ((b & 9'b010010010) == 9'b010010010) || ((b & 9'b100100100) == 9'b100100100) ||
           ((b & 9'b100010001) == 9'b100010001) || ((b & 9'b001010100) == 9'b001010100);
  endfunction

  assign game_winner = has_line(xb) ? 2'b01 : (has_line(ob) ? 2'b10 : 2'b00);

  always @(posedge clk) begin
    if (!reset || game_clear) begin
      xb <= '0;
      ob <= '0;
    end else if (move_valid) begin
      if (move_player) ob[move_pos - 4'd1] <= 1'b1;
      else             xb[move_pos - 4'd1] <= 1'b1;
    end
  end

  // Scoreboard: every issued move must match the oldest expected accepted move.
  always @(negedge clk) begin
    if (reset && move_valid) begin
      chk_eq("move_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk_eq("move_player_pos", {27'd0, move_player, move_pos}, {27'd0, mon_e});
      end
    end
  end

  task automatic do_move(input bit p, input logic [3:0] pos, input bit ok);
    bit got;
    if (ok) exp_q.push_back({p, pos});
    if (p) begin o_req = 1'b1; o_pos = pos; end
    else   begin x_req = 1'b1; x_pos = pos; end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (p ? o_ack : x_ack) got = 1'b1;
    end
    chk_eq(p ? "o_ack_seen" : "x_ack_seen", 32'(got), 32'd1);
    chk_eq("reject", 32'(reject), 32'(!ok));
    @(posedge clk);
    #1;
    if (p) o_req = 1'b0;
    else   x_req = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk_eq("game_clear_pulse", 32'(game_clear), 32'd1);
    chk_eq("count_after_start", 32'(move_count), 32'd0);
    chk_eq("result_after_start", 32'(result), 32'd0);
    chk_eq("over_after_start", 32'(game_over), 32'd0);
    @(negedge clk);
    chk_eq("game_clear_drop", 32'(game_clear), 32'd0);
  endtask

  task automatic check_done(input logic [1:0] res, input logic [3:0] cnt);
    repeat (3) @(negedge clk);
    chk_eq("game_over", 32'(game_over), 32'd1);
    chk_eq("result", 32'(result), 32'(res));
    chk_eq("move_count", 32'(move_count), 32'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq(tag, {15'd0, x_ack, o_ack, reject, game_clear, move_valid, move_player, move_pos,
                 turn, move_count, game_over, result}, 32'd0);
  endtask

  initial begin
    int oacks;
    reset = 1'b0; start = 1'b0;
    x_req = 1'b0; o_req = 1'b0; x_pos = '0; o_pos = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1 reset = 1'b1;

    // X wins down column 2-5-8.
    start_game();
    do_move(0, 4'd5, 1); do_move(1, 4'd1, 1); do_move(0, 4'd7, 1);
    do_move(1, 4'd3, 1); do_move(0, 4'd2, 1); do_move(1, 4'd6, 1);
    @(negedge clk);
    chk_eq("no_over_mid_game", 32'(game_over), 32'd0);
    do_move(0, 4'd8, 1);
    check_done(2'b01, 4'd7);

    // Draw on the ninth move.
    start_game();
    do_move(0, 4'd5, 1); do_move(1, 4'd1, 1); do_move(0, 4'd9, 1);
    do_move(1, 4'd3, 1); do_move(0, 4'd2, 1); do_move(1, 4'd8, 1);
    do_move(0, 4'd7, 1); do_move(1, 4'd6, 1); do_move(0, 4'd4, 1);
    check_done(2'b11, 4'd9);

    // Illegal moves: occupied square and out-of-range squares.
    start_game();
    do_move(0, 4'd5, 1);
    do_move(1, 4'd5, 0);
    @(negedge clk);
    chk_eq("turn_after_reject", 32'(turn), 32'd1);
    do_move(1, 4'd0, 0);
    do_move(1, 4'd10, 0);
    chk_eq("count_after_rejects", 32'(move_count), 32'd1);
    do_move(1, 4'd1, 1);

    // O requesting during X's turn is never acknowledged.
    o_req = 1'b1; o_pos = 4'd9;
    oacks = 0;
    repeat (OUT_OF_TURN_HOLD) begin
      @(negedge clk);
      if (o_ack) oacks++;
    end
    chk_eq("o_ack_out_of_turn", 32'(oacks), 32'd0);
    chk_eq("turn_x_held", 32'(turn), 32'd0);
    o_req = 1'b0;
    do_move(0, 4'd2, 1);
    do_move(1, 4'd9, 1);
    @(negedge clk);
    chk_eq("count_before_reset", 32'(move_count), 32'd4);

    // Reset mid-game.
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("midgame_reset_outputs");
    chk_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    start_game();

    // Idle turn: forfeits only with the timeout feature built in.
    repeat (5) @(negedge clk);
    chk_eq("turn_after_idle", 32'(turn), 32'(TURN_AFTER_IDLE));
    chk_eq("count_after_idle", 32'(move_count), 32'd0);

    repeat (2) @(negedge clk);
    chk_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
